// File: rtl/pkt_buf_pkg.sv
// Shared definitions for the packet cell buffer ingress path.
// Contents:
//   CELL_NUM / CELL_BEATS / BEAT_BYTES / CELL_BYTES / LEN_WIDTH : default geometry
//   CELL_ID_W  : cell id width for the default geometry
//   wr_state_t : cell writer FSM states
//   cell_desc_t: descriptor {cell_id, len} handed to the queue stage
package pkt_buf_pkg;

    localparam int unsigned CELL_NUM   = 64;
    localparam int unsigned CELL_BEATS = 24;
    localparam int unsigned BEAT_BYTES = 64;
    localparam int unsigned CELL_BYTES = CELL_BEATS * BEAT_BYTES;
    localparam int unsigned LEN_WIDTH  = 16;
    localparam int unsigned CELL_ID_W  = $clog2(CELL_NUM);

    typedef enum logic [2:0] {
        IDLE,
        ALLOC,
        WRITE,
        DESC,
        DROP,
        FREE
    } wr_state_t;

    typedef struct packed {
        logic [CELL_ID_W-1:0] cell_id;
        logic [LEN_WIDTH-1:0] len;
    } cell_desc_t;

endpackage

// File: rtl/pkt_cell_writer_if.sv
// AXI-Stream packet ingress bundle.
// Signals:
//   tdata  : beat data
//   tkeep  : byte enables, contiguous from bit 0
//   tvalid : beat valid (source)
//   tready : beat accept (sink)
//   tlast  : last beat of packet
// Modports: master = stream source, slave = stream sink.
interface pkt_cell_writer_if #(
    parameter int DATA_WIDTH = 512,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8
);

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;

    modport master (
        output tdata,
        output tkeep,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tkeep,
        input  tvalid,
        input  tlast,
        output tready
    );

endinterface

// File: rtl/pkt_cell_writer_keep_popcount.sv
// Combinational byte count of a tkeep vector.
// Ports:
//   keep  : byte enables
//   count : number of set bits in keep
module keep_popcount #(
    parameter int KEEP_WIDTH  = 64,
    parameter int COUNT_WIDTH = 16
) (
    input  logic [KEEP_WIDTH-1:0]  keep,
    output logic [COUNT_WIDTH-1:0] count
);

    always_comb begin
        count = '0;
        for (int unsigned i = 0; i < KEEP_WIDTH; i++) begin
            count = count + COUNT_WIDTH'(keep[i]);
        end
    end

endmodule

// File: rtl/pkt_cell_writer.sv
// Ingress cell writer: requests one cell per AXI-Stream packet from the
// allocator, writes the packet beats into cell memory, then emits a
// {cell id, byte length} descriptor. A packet is dropped when allocation
// fails; a packet longer than one cell is dropped and its cell returned
// through the free port.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   s_axis               : packet stream in (slave modport)
//   alloc_mem_*          : one-cycle cell request / same-cycle grant
//   free_mem_*, free_cell_id : cell return, held until free_mem_ready
//   mem_wr_*             : registered cell memory write port, addr = {cell, beat}
//   m_desc_*             : descriptor out, held until m_desc_ready
//   drop_count           : saturating dropped-packet counter
module pkt_cell_writer #(
    parameter int DATA_WIDTH    = 512,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int LEN_WIDTH     = pkt_buf_pkg::LEN_WIDTH,
    parameter int CELL_NUM      = pkt_buf_pkg::CELL_NUM,
    parameter int CELL_ID_WIDTH = $clog2(CELL_NUM),
    parameter int CELL_BEATS    = pkt_buf_pkg::CELL_BEATS,
    parameter int BEAT_WIDTH    = $clog2(CELL_BEATS)
) (
    input  logic                            clk,
    input  logic                            rst,

    pkt_cell_writer_if.slave                s_axis,

    output logic                            alloc_mem_req,
    output logic [LEN_WIDTH-1:0]            alloc_mem_size,
    input  logic [CELL_ID_WIDTH-1:0]        alloc_cell_id,
    input  logic                            alloc_mem_success,

    output logic                            free_mem_req,
    input  logic                            free_mem_ready,
    output logic [LEN_WIDTH-1:0]            free_mem_size,
    output logic [CELL_ID_WIDTH-1:0]        free_cell_id,

    output logic                            mem_wr_en,
    output logic [CELL_ID_WIDTH+BEAT_WIDTH-1:0] mem_wr_addr,
    output logic [DATA_WIDTH-1:0]           mem_wr_data,
    output logic [KEEP_WIDTH-1:0]           mem_wr_strb,

    output logic                            m_desc_valid,
    input  logic                            m_desc_ready,
    output logic [CELL_ID_WIDTH-1:0]        m_desc_cell_id,
    output logic [LEN_WIDTH-1:0]            m_desc_len,

    output logic [31:0]                     drop_count
);

    import pkt_buf_pkg::*;

    localparam logic [LEN_WIDTH-1:0] CELL_SIZE = LEN_WIDTH'(CELL_BEATS * KEEP_WIDTH);

    // A full cell's byte count must fit in the length field.
    if (CELL_BEATS * KEEP_WIDTH >= (1 << LEN_WIDTH)) begin : g_len_check
        $error("pkt_cell_writer: CELL_BEATS*KEEP_WIDTH does not fit in LEN_WIDTH");
    end
    if (CELL_ID_WIDTH < $clog2(CELL_NUM)) begin : g_id_check
        $error("pkt_cell_writer: CELL_ID_WIDTH too narrow for CELL_NUM");
    end
    if ((1 << BEAT_WIDTH) < CELL_BEATS) begin : g_beat_check
        $error("pkt_cell_writer: BEAT_WIDTH too narrow for CELL_BEATS");
    end

    wr_state_t state;
    wr_state_t state_next;

    logic [CELL_ID_WIDTH-1:0] cell_q;
    logic [BEAT_WIDTH-1:0]    beat_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic                     held_q;      // cell owned while draining an overflowed packet
    logic [LEN_WIDTH-1:0]     keep_bytes;

    logic beat_fire;
    logic last_slot;
    logic overflow;
    logic drop_inc;

    keep_popcount #(
        .KEEP_WIDTH  (KEEP_WIDTH),
        .COUNT_WIDTH (LEN_WIDTH)
    ) u_keep_popcount (
        .keep  (s_axis.tkeep),
        .count (keep_bytes)
    );

    assign s_axis.tready = (state == WRITE) || (state == DROP);
    assign beat_fire     = s_axis.tvalid && s_axis.tready;
    assign last_slot     = (beat_q == BEAT_WIDTH'(CELL_BEATS - 1));
    // Final cell slot consumed but the packet continues.
    assign overflow      = (state == WRITE) && beat_fire && !s_axis.tlast && last_slot;
    assign drop_inc      = ((state == ALLOC) && !alloc_mem_success) || overflow;

    assign alloc_mem_req  = (state == ALLOC);
    assign alloc_mem_size = (state == ALLOC) ? CELL_SIZE : '0;

    assign free_mem_req   = (state == FREE);
    assign free_mem_size  = (state == FREE) ? CELL_SIZE : '0;
    assign free_cell_id   = (state == FREE) ? cell_q : '0;

    assign m_desc_valid   = (state == DESC);
    assign m_desc_cell_id = (state == DESC) ? cell_q : '0;
    assign m_desc_len     = (state == DESC) ? len_q  : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (s_axis.tvalid) begin
                    state_next = ALLOC;
                end
            end
            ALLOC: begin
                state_next = alloc_mem_success ? WRITE : DROP;
            end
            WRITE: begin
                if (beat_fire) begin
                    if (s_axis.tlast) begin
                        state_next = DESC;
                    end else if (last_slot) begin
                        state_next = DROP;
                    end
                end
            end
            DESC: begin
                if (m_desc_ready) begin
                    state_next = IDLE;
                end
            end
            DROP: begin
                if (beat_fire && s_axis.tlast) begin
                    state_next = held_q ? FREE : IDLE;
                end
            end
            FREE: begin
                if (free_mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cell_q      <= '0;
            beat_q      <= '0;
            len_q       <= '0;
            held_q      <= 1'b0;
            drop_count  <= '0;
            mem_wr_en   <= 1'b0;
            mem_wr_addr <= '0;
            mem_wr_data <= '0;
            mem_wr_strb <= '0;
        end else begin
            mem_wr_en <= 1'b0;

            if ((state == ALLOC) && alloc_mem_success) begin
                cell_q <= alloc_cell_id;
                beat_q <= '0;
                len_q  <= '0;
            end

            if ((state == WRITE) && beat_fire) begin
                mem_wr_en   <= 1'b1;
                mem_wr_addr <= {cell_q, beat_q};
                mem_wr_data <= s_axis.tdata;
                mem_wr_strb <= s_axis.tkeep;
                beat_q      <= beat_q + 1'b1;
                len_q       <= len_q + keep_bytes;
            end

            if (overflow) begin
                held_q <= 1'b1;
            end else if ((state == FREE) && free_mem_ready) begin
                held_q <= 1'b0;
            end

            if (drop_inc && (drop_count != '1)) begin
                drop_count <= drop_count + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_pkt_cell_writer.sv
// Self-checking bench for pkt_cell_writer: directed scenarios followed by
// randomized packets, compared against a transaction-level packet model.
module tb_pkt_cell_writer;

    import pkt_buf_pkg::*;

    localparam int DW  = 512;
    localparam int KW  = DW / 8;
    localparam int LW  = 16;
    localparam int CIW = 6;
    localparam int BW  = 5;
    localparam int CB  = 24;
    localparam int AW  = CIW + BW;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [KW-1:0] strb;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pkt_cell_writer_if #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW)) s_axis ();

    logic           alloc_mem_req;
    logic [LW-1:0]  alloc_mem_size;
    logic [CIW-1:0] alloc_cell_id;
    logic           alloc_mem_success;
    logic           free_mem_req;
    logic           free_mem_ready;
    logic [LW-1:0]  free_mem_size;
    logic [CIW-1:0] free_cell_id;
    logic           mem_wr_en;
    logic [AW-1:0]  mem_wr_addr;
    logic [DW-1:0]  mem_wr_data;
    logic [KW-1:0]  mem_wr_strb;
    logic           m_desc_valid;
    logic           m_desc_ready;
    logic [CIW-1:0] m_desc_cell_id;
    logic [LW-1:0]  m_desc_len;
    logic [31:0]    drop_count;

    pkt_cell_writer #(
        .DATA_WIDTH    (DW),
        .KEEP_WIDTH    (KW),
        .LEN_WIDTH     (LW),
        .CELL_NUM      (64),
        .CELL_ID_WIDTH (CIW),
        .CELL_BEATS    (CB),
        .BEAT_WIDTH    (BW)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .s_axis            (s_axis),
        .alloc_mem_req     (alloc_mem_req),
        .alloc_mem_size    (alloc_mem_size),
        .alloc_cell_id     (alloc_cell_id),
        .alloc_mem_success (alloc_mem_success),
        .free_mem_req      (free_mem_req),
        .free_mem_ready    (free_mem_ready),
        .free_mem_size     (free_mem_size),
        .free_cell_id      (free_cell_id),
        .mem_wr_en         (mem_wr_en),
        .mem_wr_addr       (mem_wr_addr),
        .mem_wr_data       (mem_wr_data),
        .mem_wr_strb       (mem_wr_strb),
        .m_desc_valid      (m_desc_valid),
        .m_desc_ready      (m_desc_ready),
        .m_desc_cell_id    (m_desc_cell_id),
        .m_desc_len        (m_desc_len),
        .drop_count        (drop_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Observed transactions
    wr_t        got_wr[$];
    cell_desc_t got_desc[$];
    cell_desc_t got_free[$];
    int         got_alloc = 0;
    int         cyc = 0;
    int         first_wr_cyc = -1;
    int         start_cyc = -1;
    int         desc_cnt = 0, last_desc_wait = 0;
    int         free_cnt = 0, last_free_wait = 0;
    bit         pend_desc = 0, pend_free = 0;
    logic [CIW-1:0] prev_desc_cell, prev_free_cell;
    logic [LW-1:0]  prev_desc_len, prev_free_size;

    // Sink-side controls
    bit rand_rdy = 0;
    bit gap_en   = 0;
    int desc_lo  = 0;
    int free_lo  = 0;

    // Model state
    int exp_drops = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        if (desc_lo > 0) begin
            m_desc_ready = 1'b0;
            if (m_desc_valid) desc_lo--;
        end else begin
            m_desc_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (free_lo > 0) begin
            free_mem_ready = 1'b0;
            if (free_mem_req) free_lo--;
        end else begin
            free_mem_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            pend_desc = 0;
            pend_free = 0;
            desc_cnt  = 0;
            free_cnt  = 0;
        end else begin
            if (mem_wr_en) begin
                got_wr.push_back('{addr: mem_wr_addr, data: mem_wr_data, strb: mem_wr_strb});
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
            end
            if (alloc_mem_req) begin
                got_alloc++;
                check("alloc_size", alloc_mem_size, 1536);
            end
            if (m_desc_valid) begin
                check("desc_tready_low", s_axis.tready, 1'b0);
                check("desc_no_alloc", alloc_mem_req, 1'b0);
                if (pend_desc) begin
                    check("desc_stable_cell", m_desc_cell_id, prev_desc_cell);
                    check("desc_stable_len", m_desc_len, prev_desc_len);
                end
                desc_cnt++;
                if (m_desc_ready) begin
                    got_desc.push_back('{cell_id: m_desc_cell_id, len: m_desc_len});
                    last_desc_wait = desc_cnt;
                    desc_cnt = 0;
                end
            end
            if (free_mem_req) begin
                if (pend_free) begin
                    check("free_stable_id", free_cell_id, prev_free_cell);
                    check("free_stable_size", free_mem_size, prev_free_size);
                end
                free_cnt++;
                if (free_mem_ready) begin
                    got_free.push_back('{cell_id: free_cell_id, len: free_mem_size});
                    last_free_wait = free_cnt;
                    free_cnt = 0;
                end
            end
            pend_desc      = m_desc_valid && !m_desc_ready;
            pend_free      = free_mem_req && !free_mem_ready;
            prev_desc_cell = m_desc_cell_id;
            prev_desc_len  = m_desc_len;
            prev_free_cell = free_cell_id;
            prev_free_size = free_mem_size;
        end
    end

    task automatic clear_obs();
        got_wr.delete();
        got_desc.delete();
        got_free.delete();
        got_alloc    = 0;
        first_wr_cyc = -1;
        start_cyc    = -1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, s_axis.tready, 1'b0);
        check({tag, "_alloc_req"}, alloc_mem_req, 1'b0);
        check({tag, "_alloc_size"}, alloc_mem_size, 0);
        check({tag, "_free_req"}, free_mem_req, 1'b0);
        check({tag, "_free_size"}, free_mem_size, 0);
        check({tag, "_free_id"}, free_cell_id, 0);
        check({tag, "_wr_en"}, mem_wr_en, 1'b0);
        check({tag, "_wr_addr"}, mem_wr_addr, 0);
        check({tag, "_wr_data"}, mem_wr_data, 0);
        check({tag, "_wr_strb"}, mem_wr_strb, 0);
        check({tag, "_desc_valid"}, m_desc_valid, 1'b0);
        check({tag, "_desc_cell"}, m_desc_cell_id, 0);
        check({tag, "_desc_len"}, m_desc_len, 0);
        check({tag, "_drop_count"}, drop_count, 0);
    endtask

    // Sends one packet of n beats (last beat carrying last_bytes valid bytes)
    // with the allocator answering ok/id, then compares everything the DUT
    // produced for it against the packet-level model. abort_at >= 0 pulses
    // reset while that beat is being presented and skips the comparison.
    task automatic send_pkt(input int n, input int last_bytes, input bit ok,
                            input int id, input int abort_at);
        logic [DW-1:0] data[$];
        logic [KW-1:0] keep[$];
        logic [KW-1:0] full;
        logic [DW-1:0] d;
        wr_t           exp_wr[$];
        cell_desc_t    exp_desc[$];
        cell_desc_t    exp_free[$];
        int            stored;
        int            i;
        int            budget;
        bit            hs;
        bit            v;

        full = '1;
        for (int b = 0; b < n; b++) begin
            for (int w = 0; w < DW / 32; w++) d[w*32 +: 32] = $urandom();
            data.push_back(d);
            keep.push_back((b == n - 1) ? (full >> (KW - last_bytes)) : full);
        end

        // Packet-level model
        stored = ok ? ((n < CB) ? n : CB) : 0;
        for (int b = 0; b < stored; b++) begin
            exp_wr.push_back('{addr: AW'((id << BW) | b), data: data[b], strb: keep[b]});
        end
        if (ok && n <= CB) exp_desc.push_back('{cell_id: CIW'(id), len: LW'((n - 1) * KW + last_bytes)});
        if (ok && n > CB)  exp_free.push_back('{cell_id: CIW'(id), len: LW'(CB * KW)});
        if (abort_at < 0 && (!ok || n > CB)) exp_drops++;

        clear_obs();
        @(posedge clk); #2;
        alloc_mem_success = ok;
        alloc_cell_id     = CIW'(id);

        i = 0;
        budget = 0;
        while (i < n && budget < 400) begin
            if (i == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #2;
                s_axis.tvalid = 1'b0;
                s_axis.tlast  = 1'b0;
                @(negedge clk);
                check_all_zero("midrst");
                @(posedge clk); #2;
                rst = 1'b0;
                exp_drops = 0;
                clear_obs();
                return;
            end
            v = !gap_en || ($urandom_range(0, 3) != 0);
            s_axis.tvalid = v;
            s_axis.tdata  = data[i];
            s_axis.tkeep  = keep[i];
            s_axis.tlast  = (i == n - 1);
            if (v && start_cyc < 0) start_cyc = cyc;
            @(negedge clk);
            hs = s_axis.tvalid && s_axis.tready;
            @(posedge clk); #2;
            if (hs) i++;
            budget++;
        end
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        if (i < n) check("pkt_accept_timeout", i, n);

        budget = 0;
        while (budget < 80 && !(got_desc.size() >= exp_desc.size() &&
                                got_free.size() >= exp_free.size())) begin
            @(posedge clk); #2;
            budget++;
        end
        if (budget >= 80) check("completion_timeout", budget, 0);
        repeat (3) @(posedge clk);
        #2;

        check("wr_count", got_wr.size(), exp_wr.size());
        for (int k = 0; k < exp_wr.size() && k < got_wr.size(); k++) begin
            check("wr_addr", got_wr[k].addr, exp_wr[k].addr);
            check("wr_data", got_wr[k].data, exp_wr[k].data);
            check("wr_strb", got_wr[k].strb, exp_wr[k].strb);
        end
        check("desc_count", got_desc.size(), exp_desc.size());
        if (exp_desc.size() == 1 && got_desc.size() == 1) begin
            check("desc_cell", got_desc[0].cell_id, exp_desc[0].cell_id);
            check("desc_len", got_desc[0].len, exp_desc[0].len);
        end
        check("free_count", got_free.size(), exp_free.size());
        if (exp_free.size() == 1 && got_free.size() == 1) begin
            check("free_id", got_free[0].cell_id, exp_free[0].cell_id);
            check("free_size", got_free[0].len, exp_free[0].len);
        end
        check("alloc_reqs", got_alloc, 1);
        check("drop_count", drop_count, exp_drops);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_axis.tvalid     = 1'b0;
        s_axis.tdata      = '0;
        s_axis.tkeep      = '0;
        s_axis.tlast      = 1'b0;
        alloc_mem_success = 1'b0;
        alloc_cell_id     = '0;
        m_desc_ready      = 1'b0;
        free_mem_ready    = 1'b0;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #2;
        rst = 1'b0;

        // 3-beat packet into cell 5, last tkeep 0xFF, no gaps
        send_pkt(3, 8, 1'b1, 5, -1);
        check("first_write_latency", first_wr_cyc - start_cyc, 3);

        // Allocation failure on a 2-beat packet
        send_pkt(2, 64, 1'b0, 0, -1);

        // 26-beat overflow into cell 9, free port stalled 3 cycles
        free_lo = 3;
        send_pkt(26, 64, 1'b1, 9, -1);
        check("free_wait_cycles", last_free_wait, 4);

        // Descriptor back-pressure, then the next packet allocates normally
        desc_lo = 5;
        send_pkt(4, 20, 1'b1, 11, -1);
        check("desc_wait_cycles", last_desc_wait, 6);
        send_pkt(1, 64, 1'b1, 12, -1);

        // Back-to-back single-beat packets
        for (int g = 0; g < 3; g++) send_pkt(1, 64, 1'b1, g, -1);

        // Reset during beat 4, then a normal packet
        send_pkt(10, 64, 1'b1, 7, 4);
        send_pkt(2, 30, 1'b1, 13, -1);

        // Randomized packets with source gaps and sink back-pressure
        gap_en   = 1;
        rand_rdy = 1;
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, 30), $urandom_range(1, KW),
                     ($urandom_range(0, 4) != 0), $urandom_range(0, 63), -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_cell_writer.md
Name: pkt_cell_writer

Overview:
- Ingress stage sitting directly upstream of the cell allocator (rand_mem_alloc).
- Accepts an AXI-Stream packet and requests one free cell per packet.
- Writes the packet beats into the cell memory, then emits a descriptor (cell id, byte length) to the PIFO/queue stage.
- Drops the packet on allocation failure; drops and returns the cell via a free port if the packet overflows the cell.

Parameters:
DATA_WIDTH, 512, stream/memory data width in bits
KEEP_WIDTH, DATA_WIDTH/8, tkeep/strobe width
LEN_WIDTH, 16, byte-length width (matches allocator)
CELL_NUM, 64, number of cells (matches allocator)
CELL_ID_WIDTH, $clog2(CELL_NUM), cell id width
CELL_BEATS, 24, beats per cell (1536 B at 512 bit)
BEAT_WIDTH, $clog2(CELL_BEATS), beat offset width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_axis_tdata  in  DATA_WIDTH  packet data
s_axis_tkeep  in  KEEP_WIDTH  byte enables, contiguous from bit 0
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  beat accept
s_axis_tlast  in  1  last beat
alloc_mem_req  out  1  cell request to allocator
alloc_mem_size  out  LEN_WIDTH  constant CELL_BEATS*KEEP_WIDTH
alloc_cell_id  in  CELL_ID_WIDTH  granted cell
alloc_mem_success  in  1  grant, same cycle as req
free_mem_req  out  1  return cell (valid)
free_mem_ready  in  1  free port ready
free_mem_size  out  LEN_WIDTH  bytes written into returned cell
free_cell_id  out  CELL_ID_WIDTH  returned cell
mem_wr_en  out  1  cell memory write strobe
mem_wr_addr  out  CELL_ID_WIDTH+BEAT_WIDTH  {cell_id, beat}
mem_wr_data  out  DATA_WIDTH  write data
mem_wr_strb  out  KEEP_WIDTH  byte strobes (= tkeep)
m_desc_valid  out  1  descriptor valid
m_desc_ready  in  1  descriptor accept
m_desc_cell_id  out  CELL_ID_WIDTH  cell holding packet
m_desc_len  out  LEN_WIDTH  packet bytes
drop_count  out  32  saturating count of dropped packets

Behaviour:
- Reset: state=IDLE. All outputs 0: s_axis_tready, alloc_mem_req, free_mem_req, mem_wr_en, m_desc_valid, drop_count, and all data/address outputs.
- FSM states: IDLE, ALLOC, WRITE, DESC, DROP, FREE.
- IDLE: s_axis_tready=0. On s_axis_tvalid, go to ALLOC next cycle. The first beat is not consumed.
- ALLOC: alloc_mem_req=1 for exactly one cycle.
  - alloc_mem_success=1 → latch alloc_cell_id, clear beat and len counters, go to WRITE.
  - Otherwise → drop_count+1, go to DROP.
  - alloc_mem_intense is ignored.
- WRITE: s_axis_tready=1. Each tvalid&&tready beat produces one registered write the following cycle:
  - mem_wr_en=1
  - mem_wr_addr={cell, beat}
  - mem_wr_data, mem_wr_strb taken from that beat
  - beat increments; len increments by popcount(tkeep)
- WRITE latency: first write occurs at T+3 when tvalid rises at T in IDLE. Throughput is 1 beat/cycle thereafter.
- WRITE, beat with tlast → DESC. m_desc_len = len including the last beat.
- WRITE, overflow: beat index CELL_BEATS-1 accepted without tlast → drop_count+1, held-cell flag set, go to DROP. The remaining beats are not written.
- DESC: s_axis_tready=0. m_desc_valid held with stable cell id and len until m_desc_ready, then IDLE. No new allocation while a descriptor is pending.
- DROP: s_axis_tready=1, no memory writes. On the tlast beat: go to FREE if the held-cell flag is set, else IDLE.
  - A tlast beat already accepted during ALLOC failure cannot occur, because the first beat is only consumed in DROP/WRITE.
- FREE: free_mem_req=1 with free_cell_id=cell and free_mem_size=CELL_BEATS*KEEP_WIDTH, held until free_mem_ready. Then clear the flag and go to IDLE.
- Widths and saturation:
  - len is LEN_WIDTH and cannot overflow because CELL_BEATS*KEEP_WIDTH < 2^LEN_WIDTH; elaboration must check this.
  - drop_count saturates at 2^32-1.
- Single-beat packet (tlast on beat 0) is legal: one write, then the descriptor.
- Reset mid-packet returns to IDLE. The allocator is reset on the same rst, so no cell leak is handled here.

Decomposition:
- Shared package pkt_buf_pkg holds:
  - CELL_BEATS, CELL_BYTES, CELL_NUM, LEN_WIDTH constants
  - the FSM state enum
  - a descriptor struct {cell_id, len}
- One natural sub-module: keep_popcount (combinational tkeep→byte count). Everything else is flat.

Test Plan:
- Allocator grants id 5, 3-beat packet with final tkeep=0x0000_00FF → writes at addr {5,0},{5,1},{5,2}; descriptor cell=5, len=136.
- Allocator returns success=0 on 2-beat packet → no mem_wr_en, both beats consumed, drop_count=1, no descriptor.
- 26-beat packet, grant id 9 → 24 writes {9,0..23}, remaining 2 beats dropped, free_mem_req with id 9, size 1536; hold free_mem_ready low 3 cycles → req stays asserted; drop_count=1.
- m_desc_ready held low 5 cycles after a packet → m_desc_valid stable, s_axis_tready=0, alloc_mem_req=0 throughout; accept → next packet allocates.
- Back-to-back 1-beat packets, full tkeep, grants 0,1,2 → three descriptors len=64 each, writes at {0,0},{1,0},{2,0}.
- Assert rst in the middle of WRITE beat 4 → next cycle all outputs 0, state IDLE; next packet allocates normally.
